// File: rtl/mem_arbiter.sv
// Arbiter sharing one RAM port between instruction fetch and data load/store.
// Optional stall counters are built when MEM_ARBITER_STALL_CNT_EN is defined.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int SCNT_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  output logic [SCNT_W-1:0] istall_cnt,
  output logic [SCNT_W-1:0] dstall_cnt
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  localparam int              DS_W   = $clog2(MAX_DSTREAK + 1);
  localparam logic [DS_W-1:0] DS_MAX = DS_W'(MAX_DSTREAK);

  state_t          state;
  logic [DS_W-1:0] dstreak;
  logic            d_req;
  logic            i_done;
  logic            d_done;
  logic            d_grant;

  assign d_req   = dREN | dWEN;
  assign i_done  = (state == I_ACC) && ram_ready;
  assign d_done  = (state == D_ACC) && ram_ready;
  assign d_grant = d_req && !(iREN && (dstreak == DS_MAX));

  assign iwait = iREN & ~i_done;
  assign dwait = d_req & ~d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

  // The RAM-side outputs double as the grant-time latches; they are cleared
  // on completion so the RAM port is quiet (all zero) whenever we sit in IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      dstreak  <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_grant) begin
            state    <= D_ACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramREN   <= dREN & ~dWEN;
            ramWEN   <= dWEN;
          end else if (iREN) begin
            state    <= I_ACC;
            ramaddr  <= iaddr;
            ramstore <= '0;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
          end
        end
        I_ACC: begin
          if (ram_ready) begin
            state    <= IDLE;
            dstreak  <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
          end
        end
        D_ACC: begin
          if (ram_ready) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            if (!iREN)
              dstreak <= '0;
            else if (dstreak != DS_MAX)
              dstreak <= dstreak + DS_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_STALL_CNT_EN
  // Saturating per-requester stall counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istall_cnt <= '0;
      dstall_cnt <= '0;
    end else begin
      if (iwait && (istall_cnt != {SCNT_W{1'b1}}))
        istall_cnt <= istall_cnt + SCNT_W'(1);
      if (dwait && (dstall_cnt != {SCNT_W{1'b1}}))
        dstall_cnt <= dstall_cnt + SCNT_W'(1);
    end
  end
`else
  assign istall_cnt = '0;
  assign dstall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for data streak fairness, asynchronous reset and stall counters.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;
  logic        iwait;
  logic [31:0] iload;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] istall_cnt;
  logic [31:0] dstall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .SCNT_W(32)
  ) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n, i_ren, d_ren, d_wen, ready;
    logic [31:0] i_addr, d_addr, d_store, r_load;
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_addr, e_store, e_iload, e_dload;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic rst_n, i_ren, d_ren, d_wen, ready,
    input logic [31:0] i_addr, d_addr, d_store, r_load,
    input logic e_iwait, e_dwait, e_ren, e_wen,
    input logic [31:0] e_addr, e_store, e_iload, e_dload);
    vec_t v;
    v.rst_n = rst_n;   v.i_ren = i_ren;     v.d_ren = d_ren;     v.d_wen = d_wen;
    v.ready = ready;   v.i_addr = i_addr;   v.d_addr = d_addr;   v.d_store = d_store;
    v.r_load = r_load; v.e_iwait = e_iwait; v.e_dwait = e_dwait; v.e_ren = e_ren;
    v.e_wen = e_wen;   v.e_addr = e_addr;   v.e_store = e_store; v.e_iload = e_iload;
    v.e_dload = e_dload;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    nRST      = v.rst_n;
    iREN      = v.i_ren;
    dREN      = v.d_ren;
    dWEN      = v.d_wen;
    ram_ready = v.ready;
    iaddr     = v.i_addr;
    daddr     = v.d_addr;
    dstore    = v.d_store;
    ramload   = v.r_load;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("v%0d.iwait", idx),    64'(iwait),    64'(v.e_iwait));
    check($sformatf("v%0d.dwait", idx),    64'(dwait),    64'(v.e_dwait));
    check($sformatf("v%0d.ramREN", idx),   64'(ramREN),   64'(v.e_ren));
    check($sformatf("v%0d.ramWEN", idx),   64'(ramWEN),   64'(v.e_wen));
    check($sformatf("v%0d.ramaddr", idx),  64'(ramaddr),  64'(v.e_addr));
    check($sformatf("v%0d.ramstore", idx), 64'(ramstore), 64'(v.e_store));
    check($sformatf("v%0d.iload", idx),    64'(iload),    64'(v.e_iload));
    check($sformatf("v%0d.dload", idx),    64'(dload),    64'(v.e_dload));
`ifndef MEM_ARBITER_STALL_CNT_EN
    check($sformatf("v%0d.istall_cnt", idx), 64'(istall_cnt), 64'd0);
    check($sformatf("v%0d.dstall_cnt", idx), 64'(dstall_cnt), 64'd0);
`endif
  endtask

  initial begin
    // rst, iREN, dREN, dWEN, rdy, iaddr, daddr, dstore, ramload | iw, dw, REN, WEN, addr, store, iload, dload
    vecs[0]  = mk(0,1,0,0,0, 32'h40,0,0,32'h11,                   1,0,0,0, 0,0,0,0);
    vecs[1]  = mk(0,1,0,0,1, 32'h40,0,0,32'h11,                   1,0,0,0, 0,0,0,0);
    vecs[2]  = mk(1,1,0,0,0, 32'h40,0,0,32'h11,                   1,0,0,0, 0,0,0,0);
    vecs[3]  = mk(1,1,0,0,1, 32'h40,0,0,32'hCAFE0001,             0,0,1,0, 32'h40,0,32'hCAFE0001,0);
    vecs[4]  = mk(1,1,1,0,0, 0,32'h100,32'h55,0,                  1,1,0,0, 0,0,0,0);
    vecs[5]  = mk(1,1,1,0,1, 0,32'h100,32'h55,32'h12345678,       1,0,1,0, 32'h100,32'h55,0,32'h12345678);
    vecs[6]  = mk(1,1,0,0,0, 0,32'h100,32'h55,0,                  1,0,0,0, 0,0,0,0);
    vecs[7]  = mk(1,1,0,0,1, 0,32'h100,32'h55,32'h0BADF00D,       0,0,1,0, 0,0,32'h0BADF00D,0);
    vecs[8]  = mk(1,0,1,1,0, 0,32'h20,32'hDEADBEEF,0,             0,1,0,0, 0,0,0,0);
    vecs[9]  = mk(1,0,1,1,0, 0,32'h20,32'hDEADBEEF,0,             0,1,0,1, 32'h20,32'hDEADBEEF,0,0);
    vecs[10] = mk(1,0,1,1,1, 0,32'h20,32'hDEADBEEF,32'h77,        0,0,0,1, 32'h20,32'hDEADBEEF,0,32'h77);
    vecs[11] = mk(1,0,1,0,0, 0,32'h300,0,0,                       0,1,0,0, 0,0,0,0);
    vecs[12] = mk(1,0,0,0,0, 0,32'h300,0,0,                       0,0,1,0, 32'h300,0,0,0);
    vecs[13] = mk(1,0,0,0,0, 0,32'h300,0,0,                       0,0,1,0, 32'h300,0,0,0);
    vecs[14] = mk(1,0,0,0,0, 0,32'h300,0,0,                       0,0,1,0, 32'h300,0,0,0);
    vecs[15] = mk(1,0,0,0,1, 0,32'h300,0,32'h99,                  0,0,1,0, 32'h300,0,0,32'h99);
    vecs[16] = mk(1,0,0,0,1, 0,0,0,32'h5,                         0,0,0,0, 0,0,0,0);

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // Instruction held against continuous data writes: four data grants, then one fetch.
    @(negedge CLK);
    nRST = 1'b1; iREN = 1'b1; iaddr = 32'h400;
    dREN = 1'b0; dWEN = 1'b1; daddr = 32'h500; dstore = 32'hA5A5;
    ram_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      ramload = 32'h1000 + 32'(c);
      #1;
      if (c % 2 == 0) begin
        check($sformatf("streak c%0d idle ramREN", c), 64'(ramREN), 64'd0);
        check($sformatf("streak c%0d idle ramWEN", c), 64'(ramWEN), 64'd0);
        check($sformatf("streak c%0d idle iwait", c),  64'(iwait),  64'd1);
      end else begin
        automatic bit is_i = ((c / 2) % 5 == 4);
        check($sformatf("streak c%0d ramREN", c),   64'(ramREN),   64'(is_i));
        check($sformatf("streak c%0d ramWEN", c),   64'(ramWEN),   64'(!is_i));
        check($sformatf("streak c%0d ramaddr", c),  64'(ramaddr),  is_i ? 64'h400 : 64'h500);
        check($sformatf("streak c%0d ramstore", c), 64'(ramstore), is_i ? 64'h0 : 64'hA5A5);
        check($sformatf("streak c%0d iwait", c),    64'(iwait),    64'(!is_i));
        check($sformatf("streak c%0d dwait", c),    64'(dwait),    64'(is_i));
        check($sformatf("streak c%0d iload", c),    64'(iload),    is_i ? 64'(32'h1000 + 32'(c)) : 64'h0);
      end
      @(negedge CLK);
    end

    // Asynchronous reset during an instruction access.
    iREN = 1'b1; iaddr = 32'h60; dWEN = 1'b0; ram_ready = 1'b0;
    #1;
    check("rst_mid idle ramREN", 64'(ramREN), 64'd0);
    @(negedge CLK);
    #1;
    check("rst_mid I_ACC ramREN",  64'(ramREN),  64'd1);
    check("rst_mid I_ACC ramaddr", 64'(ramaddr), 64'h60);
    #2 nRST = 1'b0;
    #1;
    check("rst_mid async ramREN",  64'(ramREN),  64'd0);
    check("rst_mid async ramaddr", 64'(ramaddr), 64'h0);
    check("rst_mid async iwait",   64'(iwait),   64'd1);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("rst_mid released ramREN", 64'(ramREN), 64'd0);
    @(negedge CLK);
    ram_ready = 1'b1; ramload = 32'h66;
    #1;
    check("rst_mid regrant ramREN",  64'(ramREN),  64'd1);
    check("rst_mid regrant ramaddr", 64'(ramaddr), 64'h60);
    check("rst_mid regrant iwait",   64'(iwait),   64'd0);
    check("rst_mid regrant iload",   64'(iload),   64'h66);
    @(negedge CLK);
    iREN = 1'b0; ram_ready = 1'b0;

`ifdef MEM_ARBITER_STALL_CNT_EN
    @(negedge CLK);
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h70; ram_ready = 1'b0;
    #1;
    check("stall reset istall_cnt", 64'(istall_cnt), 64'd0);
    check("stall reset dstall_cnt", 64'(dstall_cnt), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (5) @(negedge CLK);
    ram_ready = 1'b1;
    #1;
    check("stall 5 istall_cnt", 64'(istall_cnt), 64'd5);
    check("stall 5 iwait",      64'(iwait),      64'd0);
    @(negedge CLK);
    iREN = 1'b0; ram_ready = 1'b0;
    #1;
    check("stall done istall_cnt", 64'(istall_cnt), 64'd5);
    check("stall done dstall_cnt", 64'(dstall_cnt), 64'd0);
`else
    #1;
    check("final istall_cnt", 64'(istall_cnt), 64'd0);
    check("final dstall_cnt", 64'(dstall_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
